// File: rtl/tick_clock_gen.sv
// Multi-channel 50%-duty divider with per-channel tick strobes; reprogramming enabled by `TICKGEN_CFG_EN.
// Latency: tick/wave registered, valid the cycle after a wrap edge; cfg_ready stays low while a request is staged.
module tick_clock_gen #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 26,
    parameter int CH_W   = 3,
    parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIVS = {26'd20_000_000, 26'd10_000_000,
                                                       26'd5_000_000, 26'd400_000, 26'd40_000}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] wave
);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  half  [NUM_CH];
    logic [NUM_CH-1:0] wave_q, wave_d, tick_q, tick_d, wrap;

    always_comb begin
        wrap   = '0;
        wave_d = wave_q;
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            wrap[i]  = en[i] && (cnt_q[i] == half[i] - CNT_W'(1));
            if (sync || !en[i]) begin
                cnt_d[i]  = '0;
                wave_d[i] = 1'b0;
            end else if (wrap[i]) begin
                cnt_d[i]  = '0;
                wave_d[i] = ~wave_q[i];
                tick_d[i] = ~wave_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            wave_q <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
            wave_q <= wave_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
    assign wave = wave_q;

`ifdef TICKGEN_CFG_EN
    localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(NUM_CH);

    logic [CNT_W-1:0] half_q [NUM_CH];
    logic [CNT_W-1:0] half_d [NUM_CH];
    logic             pend_q, pend_d, err_q, err_d, bad, apply;
    logic [CH_W-1:0]  pch_q, pch_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;

    // A staged value only lands on a wrap edge (or when the channel is idle/resynced),
    // so no half-period is ever cut short.
    always_comb begin
        bad    = (cfg_div == '0) || ({1'b0, cfg_ch} >= CH_LIM);
        apply  = 1'b0;
        half_d = half_q;
        pend_d = pend_q;
        pch_d  = pch_q;
        pdiv_d = pdiv_q;
        err_d  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pch_q == CH_W'(i)) begin
                apply = pend_q && (sync || !en[i] || wrap[i]);
                if (apply) half_d[i] = pdiv_q;
            end
        end
        if (apply) begin
            pend_d = 1'b0;
        end else if (cfg_valid && !pend_q) begin
            if (bad) begin
                err_d = 1'b1;
            end else begin
                pend_d = 1'b1;
                pch_d  = cfg_ch;
                pdiv_d = cfg_div;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) half_q[i] <= DEFAULT_DIVS[i*CNT_W +: CNT_W];
            pend_q <= 1'b0;
            err_q  <= 1'b0;
            pch_q  <= '0;
            pdiv_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) half_q[i] <= half_d[i];
            pend_q <= pend_d;
            err_q  <= err_d;
            pch_q  <= pch_d;
            pdiv_q <= pdiv_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) half[i] = half_q[i];
    end

    assign cfg_ready = ~pend_q;
    assign cfg_err   = err_q;
`else
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) half[i] = DEFAULT_DIVS[i*CNT_W +: CNT_W];
    end

    logic unused_cfg;
    assign unused_cfg = &{1'b0, cfg_valid, cfg_ch, cfg_div};
    assign cfg_ready  = 1'b0;
    assign cfg_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tick_clock_gen.sv
// Bench for tick_clock_gen with two channels and half-periods {3,2}.
module tb_tick_clock_gen;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 26;
    localparam int CH_W   = 3;
    localparam logic [NUM_CH*CNT_W-1:0] DIVS = {26'd3, 26'd2};
`ifdef TICKGEN_CFG_EN
    localparam logic CFG = 1'b1;
`else
    localparam logic CFG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       en = 2'b00;
    logic             sync = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_ready, cfg_err;
    logic [1:0]       tick, wave;

    tick_clock_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEFAULT_DIVS(DIVS)) dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_err(cfg_err), .tick(tick), .wave(wave)
    );

    always #5 clk = ~clk;

    // Reference model: each channel is a straight line in time starting at t0 with
    // wave level ph0; wave = ph0 xor floor(age/H) mod 2.
    int   cyc;
    int   t0 [2];
    int   hh [2];
    bit   ph0 [2];
    bit   ew [2];
    bit   et [2];
    bit   pend, eerr, pch;
    int   pdiv;
    int   nvec, nmis;

    typedef struct {
        logic [1:0] en;
        logic [1:0] w;
        logic [1:0] t;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit wave_at(input int c);
        int age;
        age = cyc - t0[c];
        return ph0[c] ^ (((age / hh[c]) % 2) == 1);
    endfunction

    task automatic model_reset();
        hh[0] = 2; hh[1] = 3;
        for (int c = 0; c < 2; c++) begin
            t0[c] = cyc; ph0[c] = 0; ew[c] = 0; et[c] = 0;
        end
        pend = 0; eerr = 0; pch = 0; pdiv = 0;
    endtask

    task automatic model_edge(input logic [1:0] e, input logic s, input logic v,
                              input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d);
        bit wr [2];
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (s || !e[c]) begin
                t0[c] = cyc; ph0[c] = 0; ew[c] = 0; et[c] = 0; wr[c] = 0;
            end else begin
                wr[c] = ((cyc - t0[c]) % hh[c]) == 0;
                ew[c] = wave_at(c);
                et[c] = wr[c] && ew[c];
            end
        end
`ifdef TICKGEN_CFG_EN
        eerr = 0;
        if (pend) begin
            if (s || !e[pch]) begin
                hh[pch] = pdiv; pend = 0;
            end else if (wr[pch]) begin
                hh[pch] = pdiv; t0[pch] = cyc; ph0[pch] = ew[pch]; pend = 0;
            end
        end else if (v) begin
            if (d == 0 || ch >= 2) eerr = 1;
            else begin
                pend = 1; pch = ch[0]; pdiv = int'(d);
            end
        end
`endif
    endtask

    task automatic check_model();
        chk("wave", {30'd0, wave}, {30'd0, ew[1], ew[0]});
        chk("tick", {30'd0, tick}, {30'd0, et[1], et[0]});
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, CFG & !pend});
        chk("cfg_err", {31'd0, cfg_err}, {31'd0, eerr});
    endtask

    task automatic step(input logic [1:0] e, input logic s, input logic v,
                        input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d);
        en = e; sync = s; cfg_valid = v; cfg_ch = ch; cfg_div = d;
        @(posedge clk);
        model_edge(e, s, v, ch, d);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'b11, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 2'b11; sync = 1'b0; cfg_valid = 1'b0;
        #1;
        model_reset();
        chk("rst_wave", {30'd0, wave}, 32'd0);
        chk("rst_tick", {30'd0, tick}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, {31'd0, CFG});
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            cyc++;
            model_reset();
        end
        #1 reset = 1'b0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].en, 1'b0, 1'b0, '0, '0);
            chk("tbl_wave", {30'd0, wave}, {30'd0, tbl[i].w});
            chk("tbl_tick", {30'd0, tick}, {30'd0, tbl[i].t});
            chk("tbl_ready", {31'd0, cfg_ready}, {31'd0, CFG});
        end
    endtask

    initial begin
        logic [1:0] e;
        nvec = 0; nmis = 0; cyc = 0;
        tbl[0]  = '{2'b11, 2'b00, 2'b00};
        tbl[1]  = '{2'b11, 2'b01, 2'b01};
        tbl[2]  = '{2'b11, 2'b11, 2'b10};
        tbl[3]  = '{2'b11, 2'b10, 2'b00};
        tbl[4]  = '{2'b11, 2'b10, 2'b00};
        tbl[5]  = '{2'b11, 2'b01, 2'b01};
        tbl[6]  = '{2'b11, 2'b01, 2'b00};
        tbl[7]  = '{2'b11, 2'b00, 2'b00};
        tbl[8]  = '{2'b11, 2'b10, 2'b10};
        tbl[9]  = '{2'b11, 2'b11, 2'b01};
        tbl[10] = '{2'b11, 2'b11, 2'b00};
        tbl[11] = '{2'b11, 2'b00, 2'b00};

        do_reset();
        run_table();

`ifdef TICKGEN_CFG_EN
        // Mid-period request: applied at the ch0 wrap on cycle 8, then 10-cycle tick spacing.
        do_reset();
        idle(6);
        step(2'b11, 1'b0, 1'b1, 3'd0, 26'd5);
        chk("s2_ready_staged", {31'd0, cfg_ready}, 32'd0);
        idle(1);
        chk("s2_ready_back", {31'd0, cfg_ready}, 32'd1);
        for (int k = 9; k <= 23; k++) begin
            idle(1);
            chk("s2_tick0", {31'd0, tick[0]}, {31'd0, (k == 13 || k == 23)});
        end

        // Rejected requests.
        step(2'b11, 1'b0, 1'b1, 3'd0, 26'd0);
        chk("s3_err_div0", {31'd0, cfg_err}, 32'd1);
        chk("s3_ready_div0", {31'd0, cfg_ready}, 32'd1);
        step(2'b11, 1'b0, 1'b1, 3'd3, 26'd4);
        chk("s3_err_ch", {31'd0, cfg_err}, 32'd1);
        chk("s3_ready_ch", {31'd0, cfg_ready}, 32'd1);
        idle(1);
        chk("s3_err_clear", {31'd0, cfg_err}, 32'd0);
`endif

        // Channel 1 disabled for four cycles, then re-enabled.
        for (int k = 0; k < 4; k++) begin
            step(2'b01, 1'b0, 1'b0, '0, '0);
            chk("s4_wave1_off", {31'd0, wave[1]}, 32'd0);
        end
        for (int k = 1; k <= 3; k++) begin
            idle(1);
            chk("s4_tick1", {31'd0, tick[1]}, {31'd0, (k == 3)});
        end

        // Sync with a request pending on ch1.
`ifdef TICKGEN_CFG_EN
        step(2'b11, 1'b0, 1'b1, 3'd1, 26'd4);
        chk("s5_ready_staged", {31'd0, cfg_ready}, 32'd0);
`endif
        step(2'b11, 1'b1, 1'b0, '0, '0);
        chk("s5_wave", {30'd0, wave}, 32'd0);
        chk("s5_ready", {31'd0, cfg_ready}, {31'd0, CFG});
        idle(10);

        // Reset while a request is staged restores the default periods.
        step(2'b11, 1'b0, 1'b1, 3'd0, 26'd6);
        do_reset();
        run_table();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 600) == 0) do_reset();
            e = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            step(e, ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 3)), 26'($urandom_range(0, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
